// File: rtl/pinmux_cfg_pkg.sv
// Shared types and helpers for the GPIO pin-mux configuration controller.
package pinmux_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DRAIN,
    LOAD,
    ENABLE,
    ERR
  } state_t;

  localparam int PORT_NUM_W = 8;
  localparam int OE_BIT     = PORT_NUM_W;
  localparam int OD_BIT     = PORT_NUM_W + 1;

  // Reset routing: pin j is driven by port j.
  function automatic logic [31:0] identity_sel(input int j);
    return 32'(j);
  endfunction

endpackage

// File: rtl/pinmux_cfg_regfile.sv
// Per-pin shadow registers: host write port, combinational readback and a
// validation read port, plus the whole set exposed for the atomic load.
module pinmux_cfg_regfile
  import pinmux_cfg_pkg::*;
#(
  parameter int IOWidth      = 36,
  parameter int PortNumWidth = 8,
  parameter int AddrWidth    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [AddrWidth-1:0]    waddr,
  input  logic [PortNumWidth+1:0] wdata,
  input  logic [AddrWidth-1:0]    rd_addr,
  output logic [PortNumWidth+1:0] rd_data,
  input  logic [AddrWidth-1:0]    chk_idx,
  output logic [PortNumWidth-1:0] chk_sel,
  output logic [PortNumWidth-1:0] sel [IOWidth],
  output logic [IOWidth-1:0]      oe,
  output logic [IOWidth-1:0]      od
);

  logic wr_hit;
  assign wr_hit = we && (32'(waddr) < IOWidth);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < IOWidth; j++) begin
        sel[j] <= PortNumWidth'(identity_sel(j));
      end
      oe <= '0;
      od <= '0;
    end else if (wr_hit) begin
      sel[waddr] <= wdata[PortNumWidth-1:0];
      oe[waddr]  <= wdata[PortNumWidth];
      od[waddr]  <= wdata[PortNumWidth+1];
    end
  end

  // Out-of-range readback returns zero rather than aliasing another pin.
  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < IOWidth) begin
      rd_data = {od[rd_addr], oe[rd_addr], sel[rd_addr]};
    end
  end

  assign chk_sel = sel[chk_idx];

endmodule

// File: rtl/pinmux_cfg_ctrl.sv
// Pin-mux configuration controller: validates the shadow set, releases every pin
// for a settle window, then loads routing before re-enabling the drivers.
module pinmux_cfg_ctrl
  import pinmux_cfg_pkg::*;
#(
  parameter int IOWidth      = 36,
  parameter int PortNumWidth = 8,
  parameter int AddrWidth    = 6,
  parameter int SettleCycles = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  output logic                    wr_ready,
  input  logic [AddrWidth-1:0]    wr_addr,
  input  logic [PortNumWidth+1:0] wr_data,
  input  logic [AddrWidth-1:0]    rd_addr,
  output logic [PortNumWidth+1:0] rd_data,
  input  logic                    commit_req,
  input  logic                    clr_err,
  output logic                    busy,
  output logic                    done,
  output logic                    err_flag,
  output logic [PortNumWidth-1:0] portsel_out [IOWidth],
  output logic [IOWidth-1:0]      oe_out,
  output logic [IOWidth-1:0]      od_out
);

  localparam int                   CntW    = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(IOWidth - 1);
  localparam logic [CntW-1:0]      LastCnt = CntW'(SettleCycles - 1);

  state_t                  state;
  logic                    pending;
  logic [AddrWidth-1:0]    idx;
  logic [CntW-1:0]         cnt;
  logic [PortNumWidth-1:0] sh_sel [IOWidth];
  logic [IOWidth-1:0]      sh_oe;
  logic [IOWidth-1:0]      sh_od;
  logic [PortNumWidth-1:0] chk_sel;

  assign wr_ready = (state == IDLE);

  pinmux_cfg_regfile #(
    .IOWidth     (IOWidth),
    .PortNumWidth(PortNumWidth),
    .AddrWidth   (AddrWidth)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_en & wr_ready),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .chk_idx(idx),
    .chk_sel(chk_sel),
    .sel    (sh_sel),
    .oe     (sh_oe),
    .od     (sh_od)
  );

  // Outputs are assigned on the edge entering each state, so they are live for
  // the whole cycle the state occupies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_flag <= 1'b0;
      for (int j = 0; j < IOWidth; j++) begin
        portsel_out[j] <= PortNumWidth'(identity_sel(j));
      end
      oe_out <= '0;
      od_out <= '0;
    end else begin
      done <= 1'b0;
      if (clr_err) err_flag <= 1'b0;
      if (commit_req && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (commit_req || pending) begin
            state   <= CHECK;
            idx     <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end
        CHECK: begin
          if (32'(chk_sel) >= IOWidth) begin
            state    <= ERR;
            err_flag <= 1'b1;
          end else if (idx == LastIdx) begin
            state  <= DRAIN;
            cnt    <= '0;
            oe_out <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == LastCnt) begin
            state       <= LOAD;
            portsel_out <= sh_sel;
            od_out      <= sh_od;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD: begin
          state  <= ENABLE;
          oe_out <= sh_oe;
          done   <= 1'b1;
        end
        ENABLE: begin
          // A request arriving now merges into the restart: the shadow is re-checked anyway.
          if (pending) begin
            state   <= CHECK;
            idx     <= '0;
            pending <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ERR: begin
          state   <= IDLE;
          busy    <= 1'b0;
          pending <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pinmux_cfg_ctrl.sv
// Bench for pinmux_cfg_ctrl: directed scenarios plus randomized write/commit rounds
// checked against a phase-timeline model of the shadow and active pin sets.
module tb_pinmux_cfg_ctrl;
  import pinmux_cfg_pkg::*;

  localparam int IOW = 36;
  localparam int PNW = 8;
  localparam int AW  = 6;
  localparam int SET = 4;
  localparam int L   = IOW + SET + 2;
  localparam int CW  = 4 + 2 * IOW;
  localparam int SW  = IOW * PNW;

  logic           clk        = 1'b0;
  logic           reset      = 1'b1;
  logic           wr_en      = 1'b0;
  logic           commit_req = 1'b0;
  logic           clr_err    = 1'b0;
  logic [AW-1:0]  wr_addr    = '0;
  logic [AW-1:0]  rd_addr    = '0;
  logic [PNW+1:0] wr_data    = '0;
  logic           wr_ready, busy, done, err_flag;
  logic [PNW+1:0] rd_data;
  logic [PNW-1:0] portsel_out [IOW];
  logic [IOW-1:0] oe_out, od_out;

  int total = 0;
  int bad   = 0;

  int             m_sel [IOW];
  logic [IOW-1:0] m_oe, m_od;
  int             a_sel [IOW];
  logic [IOW-1:0] a_oe, a_od;
  logic           m_err;

  always #5 clk = ~clk;

  pinmux_cfg_ctrl #(
    .IOWidth(IOW), .PortNumWidth(PNW), .AddrWidth(AW), .SettleCycles(SET)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .commit_req(commit_req),
    .clr_err(clr_err), .busy(busy), .done(done), .err_flag(err_flag),
    .portsel_out(portsel_out), .oe_out(oe_out), .od_out(od_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] dut_sel();
    logic [SW-1:0] r;
    for (int j = 0; j < IOW; j++) r[j*PNW +: PNW] = portsel_out[j];
    return r;
  endfunction

  function automatic logic [SW-1:0] act_sel();
    logic [SW-1:0] r;
    for (int j = 0; j < IOW; j++) r[j*PNW +: PNW] = PNW'(a_sel[j]);
    return r;
  endfunction

  function automatic logic [SW-1:0] shd_sel();
    logic [SW-1:0] r;
    for (int j = 0; j < IOW; j++) r[j*PNW +: PNW] = PNW'(m_sel[j]);
    return r;
  endfunction

  function automatic logic [SW-1:0] ident_sel();
    logic [SW-1:0] r;
    for (int j = 0; j < IOW; j++) r[j*PNW +: PNW] = PNW'(j);
    return r;
  endfunction

  function automatic logic [PNW+1:0] model_rd(input int a);
    logic [PNW+1:0] r;
    r = '0;
    if (a < IOW) begin
      r[PNW-1:0] = PNW'(m_sel[a]);
      r[OE_BIT]  = m_oe[a];
      r[OD_BIT]  = m_od[a];
    end
    return r;
  endfunction

  function automatic int first_bad();
    for (int j = 0; j < IOW; j++) if (m_sel[j] >= IOW) return j;
    return -1;
  endfunction

  function automatic logic [CW-1:0] dut_ctl();
    return {busy, done, wr_ready, err_flag, oe_out, od_out};
  endfunction

  task automatic model_reset();
    for (int j = 0; j < IOW; j++) begin
      m_sel[j] = j;
      a_sel[j] = j;
    end
    m_oe = '0; m_od = '0; a_oe = '0; a_od = '0; m_err = 1'b0;
  endtask

  task automatic model_apply();
    for (int j = 0; j < IOW; j++) a_sel[j] = m_sel[j];
    a_oe = m_oe;
    a_od = m_od;
  endtask

  task automatic write_pin(input int a, input int s, input logic oe, input logic od);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = '0;
    wr_data[PNW-1:0] = PNW'(s);
    wr_data[OE_BIT] = oe;
    wr_data[OD_BIT] = od;
    tick();
    wr_en = 1'b0;
    if (a < IOW) begin
      m_sel[a] = s; m_oe[a] = oe; m_od[a] = od;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    tick();
    total++;
    if (dut_sel() !== ident_sel()) begin
      bad++; $display("FAIL reset_sel got %h want %h", dut_sel(), ident_sel());
    end
    total++;
    if (dut_ctl() !== {4'b0010, {IOW{1'b0}}, {IOW{1'b0}}}) begin
      bad++; $display("FAIL reset_ctl got %h want %h", dut_ctl(), {4'b0010, {2*IOW{1'b0}}});
    end
    rd_addr = 5; #1;
    total++;
    if (rd_data !== {2'b00, 8'd5}) begin
      bad++; $display("FAIL reset_rd5 got %h want %h", rd_data, {2'b00, 8'd5});
    end
    rd_addr = AW'(IOW); #1;
    total++;
    if (rd_data !== model_rd(IOW)) begin
      bad++; $display("FAIL reset_rd_oor got %h want %h", rd_data, model_rd(IOW));
    end
  endtask

  task automatic test_commit_basic();
    logic [SW-1:0]  o_sel, n_sel, e_sel;
    logic [IOW-1:0] o_oe, o_od, n_oe, n_od, e_oe, e_od;
    logic [CW-1:0]  e_ctl;
    write_pin(3, 5, 1'b1, 1'b0);
    o_sel = act_sel(); o_oe = a_oe; o_od = a_od;
    n_sel = shd_sel(); n_oe = m_oe; n_od = m_od;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    for (int c = 1; c <= L + 1; c++) begin
      e_oe  = (c <= IOW) ? o_oe : (c < L) ? '0 : n_oe;
      e_od  = (c >= L - 1) ? n_od : o_od;
      e_sel = (c >= L - 1) ? n_sel : o_sel;
      e_ctl = {c <= L, c == L, c > L, m_err, e_oe, e_od};
      total++;
      if (dut_ctl() !== e_ctl) begin
        bad++; $display("FAIL basic_ctl c=%0d got %h want %h", c, dut_ctl(), e_ctl);
      end
      total++;
      if (dut_sel() !== e_sel) begin
        bad++; $display("FAIL basic_sel c=%0d got %h want %h", c, dut_sel(), e_sel);
      end
      tick();
    end
    model_apply();
  endtask

  task automatic test_error();
    int b;
    logic [CW-1:0] e_ctl;
    write_pin(7, 40, 1'b0, 1'b0);
    b = first_bad();
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    for (int c = 1; c <= b + 4; c++) begin
      e_ctl = {c <= b + 2, 1'b0, c > b + 2, c >= b + 2, a_oe, a_od};
      total++;
      if (dut_ctl() !== e_ctl) begin
        bad++; $display("FAIL err_ctl c=%0d got %h want %h", c, dut_ctl(), e_ctl);
      end
      total++;
      if (dut_sel() !== act_sel()) begin
        bad++; $display("FAIL err_sel c=%0d got %h want %h", c, dut_sel(), act_sel());
      end
      tick();
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    total++;
    if (err_flag !== 1'b0) begin
      bad++; $display("FAIL err_clear got %b want 0", err_flag);
    end
    // clr_err held across the rejecting edge: the set must still win for one cycle
    clr_err = 1'b1;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    for (int c = 1; c <= b + 4; c++) begin
      total++;
      if (err_flag !== (c == b + 2)) begin
        bad++; $display("FAIL err_setwins c=%0d got %b want %b", c, err_flag, c == b + 2);
      end
      tick();
    end
    clr_err = 1'b0;
    write_pin(7, 7, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0]  o_sel, n_sel, e_sel;
    logic [IOW-1:0] o_oe, o_od, n_oe, n_od, e_oe, e_od;
    logic [CW-1:0]  e_ctl;
    logic [PNW+1:0] rd2;
    int k, t;
    write_pin(12, 20, 1'b1, 1'b0);
    write_pin(IOW, 9, 1'b1, 1'b1);
    rd_addr = AW'(IOW); #1;
    total++;
    if (rd_data !== model_rd(IOW)) begin
      bad++; $display("FAIL oor_write_rd36 got %h want %h", rd_data, model_rd(IOW));
    end
    rd_addr = 4; #1;
    total++;
    if (rd_data !== model_rd(4)) begin
      bad++; $display("FAIL oor_write_rd4 got %h want %h", rd_data, model_rd(4));
    end
    o_sel = act_sel(); o_oe = a_oe; o_od = a_od;
    n_sel = shd_sel(); n_oe = m_oe; n_od = m_od;
    rd2 = model_rd(2);
    rd_addr = 2;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    for (int c = 1; c <= 2 * L + 1; c++) begin
      if (c == 5) begin
        wr_en = 1'b1; wr_addr = 2; wr_data = {1'b1, 1'b1, 8'd33};
      end
      if (c == 6) wr_en = 1'b0;
      commit_req = (c == 10);
      if (c > 2 * L) begin
        e_oe = n_oe; e_od = n_od; e_sel = n_sel;
        e_ctl = {3'b001, m_err, e_oe, e_od};
      end else begin
        k = (c - 1) / L;
        t = c - k * L;
        e_oe  = (t <= IOW) ? ((k == 0) ? o_oe : n_oe) : (t < L) ? '0 : n_oe;
        e_od  = (k == 0 && t < L - 1) ? o_od : n_od;
        e_sel = (k == 0 && t < L - 1) ? o_sel : n_sel;
        e_ctl = {1'b1, t == L, 1'b0, m_err, e_oe, e_od};
      end
      total++;
      if (dut_ctl() !== e_ctl) begin
        bad++; $display("FAIL b2b_ctl c=%0d got %h want %h", c, dut_ctl(), e_ctl);
      end
      total++;
      if (dut_sel() !== e_sel) begin
        bad++; $display("FAIL b2b_sel c=%0d got %h want %h", c, dut_sel(), e_sel);
      end
      if (c == 7 || c == 2 * L + 1) begin
        total++;
        if (rd_data !== rd2) begin
          bad++; $display("FAIL busy_write_dropped c=%0d got %h want %h", c, rd_data, rd2);
        end
      end
      tick();
    end
    model_apply();
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0]  o_sel, n_sel, e_sel;
    logic [IOW-1:0] o_oe, o_od, n_oe, n_od, e_oe, e_od;
    logic [CW-1:0]  e_ctl;
    write_pin(9, 11, 1'b1, 1'b1);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    repeat (IOW + 1) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (dut_sel() !== ident_sel()) begin
      bad++; $display("FAIL rstmid_sel got %h want %h", dut_sel(), ident_sel());
    end
    total++;
    if (dut_ctl() !== {4'b0010, {2*IOW{1'b0}}}) begin
      bad++; $display("FAIL rstmid_ctl got %h want %h", dut_ctl(), {4'b0010, {2*IOW{1'b0}}});
    end
    rd_addr = 9; #1;
    total++;
    if (rd_data !== model_rd(9)) begin
      bad++; $display("FAIL rstmid_rd9 got %h want %h", rd_data, model_rd(9));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    write_pin(9, 11, 1'b1, 1'b1);
    o_sel = act_sel(); o_oe = a_oe; o_od = a_od;
    n_sel = shd_sel(); n_oe = m_oe; n_od = m_od;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    for (int c = 1; c <= L + 1; c++) begin
      e_oe  = (c <= IOW) ? o_oe : (c < L) ? '0 : n_oe;
      e_od  = (c >= L - 1) ? n_od : o_od;
      e_sel = (c >= L - 1) ? n_sel : o_sel;
      e_ctl = {c <= L, c == L, c > L, m_err, e_oe, e_od};
      total++;
      if (dut_ctl() !== e_ctl) begin
        bad++; $display("FAIL rstmid_recommit_ctl c=%0d got %h want %h", c, dut_ctl(), e_ctl);
      end
      total++;
      if (dut_sel() !== e_sel) begin
        bad++; $display("FAIL rstmid_recommit_sel c=%0d got %h want %h", c, dut_sel(), e_sel);
      end
      tick();
    end
    model_apply();
  endtask

  task automatic test_random();
    logic [SW-1:0]  o_sel, n_sel, e_sel;
    logic [IOW-1:0] o_oe, o_od, n_oe, n_od, e_oe, e_od;
    logic [CW-1:0]  e_ctl;
    int n, a, s, b, ra;
    logic oe, od;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        a  = $urandom_range(0, IOW - 1);
        s  = ($urandom_range(0, 4) == 0) ? $urandom_range(IOW, 255) : $urandom_range(0, IOW - 1);
        oe = 1'($urandom);
        od = 1'($urandom);
        wr_en = 1'b1; wr_addr = AW'(a);
        wr_data = '0; wr_data[PNW-1:0] = PNW'(s); wr_data[OE_BIT] = oe; wr_data[OD_BIT] = od;
        commit_req = (i == n - 1);
        tick();
        wr_en = 1'b0; commit_req = 1'b0;
        m_sel[a] = s; m_oe[a] = oe; m_od[a] = od;
      end
      o_sel = act_sel(); o_oe = a_oe; o_od = a_od;
      n_sel = shd_sel(); n_oe = m_oe; n_od = m_od;
      b = first_bad();
      for (int c = 1; c <= ((b >= 0) ? b + 3 : L + 1); c++) begin
        ra = $urandom_range(0, 63);
        rd_addr = AW'(ra); #1;
        total++;
        if (rd_data !== model_rd(ra)) begin
          bad++; $display("FAIL rnd_rd it=%0d addr=%0d got %h want %h", it, ra, rd_data, model_rd(ra));
        end
        if (b >= 0) begin
          e_sel = o_sel;
          e_ctl = {c <= b + 2, 1'b0, c > b + 2, c >= b + 2, o_oe, o_od};
        end else begin
          e_oe  = (c <= IOW) ? o_oe : (c < L) ? '0 : n_oe;
          e_od  = (c >= L - 1) ? n_od : o_od;
          e_sel = (c >= L - 1) ? n_sel : o_sel;
          e_ctl = {c <= L, c == L, c > L, m_err, e_oe, e_od};
        end
        total++;
        if (dut_ctl() !== e_ctl) begin
          bad++; $display("FAIL rnd_ctl it=%0d c=%0d got %h want %h", it, c, dut_ctl(), e_ctl);
        end
        total++;
        if (dut_sel() !== e_sel) begin
          bad++; $display("FAIL rnd_sel it=%0d c=%0d got %h want %h", it, c, dut_sel(), e_sel);
        end
        tick();
      end
      if (b >= 0) begin
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        for (int j = 0; j < IOW; j++) begin
          if (m_sel[j] >= IOW) write_pin(j, j, m_oe[j], m_od[j]);
        end
      end else begin
        model_apply();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_commit_basic();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pinmux_cfg_ctrl.md
Name: pinmux_cfg_ctrl

Overview:
- Configuration controller for the GPIO bidirectional pin mux.
- Owns per-pin shadow registers (port-select number, output-enable, open-drain) that are written from the host bus.
- On a commit request it validates the shadow set, releases all pins (output-enable low) for a settle window, then atomically loads the active set.
- Drives the pin-mux select, oe and od inputs directly; no transient contention or glitched routing reaches the pins.

Parameters:
- IOWidth, 36, number of GPIO pins.
- PortNumWidth, 8, width of each per-pin port-select number.
- AddrWidth, 6, pin-index address width; must satisfy 2**AddrWidth >= IOWidth.
- SettleCycles, 4, clocks all outputs are held disabled before the new routing loads; minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  shadow write strobe; accepted only when wr_ready=1.
- wr_ready  out  1  high only in IDLE.
- wr_addr  in  AddrWidth  pin index.
- wr_data  in  PortNumWidth+2  bits [PortNumWidth-1:0] = port select; bit PortNumWidth = oe; bit PortNumWidth+1 = od.
- rd_addr  in  AddrWidth  shadow readback index.
- rd_data  out  PortNumWidth+2  combinational shadow readback; 0 when rd_addr >= IOWidth.
- commit_req  in  1  single-cycle request to apply the shadow set.
- clr_err  in  1  clears err_flag.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the new configuration is live.
- err_flag  out  1  sticky; set when a commit is rejected.
- portsel_out  out  [IOWidth] x PortNumWidth  active per-pin select (unpacked array).
- oe_out  out  IOWidth  active output-enable.
- od_out  out  IOWidth  active open-drain.

Behaviour:
- Reset (async):
  - Shadow and active portsel[j] = j (identity routing).
  - Shadow and active oe and od = 0.
  - State IDLE; busy=0, done=0, err_flag=0, wr_ready=1, pending=0.
  - Reset mid-sequence aborts the commit and restores all of the above immediately.
- All outputs except rd_data and wr_ready are registered.
- Writes:
  - Happen on wr_en & wr_ready.
  - wr_addr >= IOWidth is ignored.
  - wr_en while wr_ready=0 is dropped; the host must check wr_ready first.
- State IDLE:
  - commit_req, or pending=1 -> CHECK with idx=0; pending is cleared.
  - A write and a commit in the same IDLE cycle: the write lands first and is included in the commit.
- State CHECK:
  - One pin per cycle.
  - If shadow portsel[idx] >= IOWidth -> ERR.
  - Else, if idx == IOWidth-1 -> DRAIN with cnt=0.
  - Else idx++.
  - Active outputs are unchanged during CHECK.
- State DRAIN:
  - oe_out = 0 on all pins; portsel_out and od_out hold their old values.
  - Lasts SettleCycles cycles, then -> LOAD.
- State LOAD:
  - portsel_out and od_out load from shadow; oe_out stays 0.
  - -> ENABLE.
- State ENABLE:
  - oe_out loads from shadow; done=1 for this cycle.
  - -> CHECK if pending, else IDLE.
- State ERR:
  - err_flag set; active outputs untouched (oe is never dropped).
  - -> IDLE; a pending request is discarded.
- commit_req while busy sets pending (one level deep; further requests merge).
- clr_err and an err set in the same cycle: set wins.
- Latency: commit_req high at edge 0 gives the sequence below; with defaults (IOWidth=36, SettleCycles=4) done is high in cycle 42.
  - CHECK occupies cycles 1..IOWidth.
  - DRAIN occupies the next SettleCycles cycles.
  - LOAD occupies cycle IOWidth+SettleCycles+1.
  - ENABLE (done high, new oe live) occupies cycle IOWidth+SettleCycles+2.
- A rejected commit reports err after idx+1 CHECK cycles.

Decomposition:
- Package pinmux_cfg_pkg:
  - state enum {IDLE, CHECK, DRAIN, LOAD, ENABLE, ERR}.
  - Field-offset localparams OE_BIT = PortNumWidth and OD_BIT = PortNumWidth+1.
  - Function identity_sel(j).
- One sub-module, pinmux_cfg_regfile: shadow storage with write port, readback port and CHECK index read port.
- The FSM, counters and active registers stay in the top module.

Test Plan:
- Reset then idle: portsel_out[j]=j for all j, oe_out=0, od_out=0, busy=0, rd_data at addr 5 = {0,0,8'd5}.
- Write pin 3 = {od=0, oe=1, sel=5}, then commit:
  - busy for cycles 1..42.
  - oe_out=0 for cycles 37..41.
  - portsel_out[3]=5 from cycle 41.
  - oe_out[3]=1 and done pulse in cycle 42.
- With pin 3 active (oe=1), write pin 7 sel=40, then commit:
  - err_flag=1 after 8 CHECK cycles.
  - oe_out[3] never drops; portsel_out[7] stays 7.
  - clr_err then clears err_flag.
- Second commit_req at cycle 10 of a running commit: first done at cycle 42, second done at cycle 84 with no IDLE cycle in between. wr_en at addr 36 and wr_en while busy leave rd_data unchanged.
- Assert reset during DRAIN (cycle 38): outputs return to identity, oe=0 asynchronously; busy=0; the subsequent commit completes normally.
